// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU op/result-select encodings,
// divider FSM state encodings, the decode-to-execute bundle and op helpers.
// No logic; imported by ex_stage and div_unit.
package ex_stage_pkg;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int ALUOP_W    = 8;
  localparam int ALUSEL_W   = 3;

  // aluop encodings
  localparam logic [ALUOP_W-1:0] EXE_NOP_OP  = 8'b0000_0000;
  localparam logic [ALUOP_W-1:0] EXE_AND_OP  = 8'b0010_0100;
  localparam logic [ALUOP_W-1:0] EXE_OR_OP   = 8'b0010_0101;
  localparam logic [ALUOP_W-1:0] EXE_XOR_OP  = 8'b0010_0110;
  localparam logic [ALUOP_W-1:0] EXE_NOR_OP  = 8'b0010_0111;
  localparam logic [ALUOP_W-1:0] EXE_SLL_OP  = 8'b0111_1100;
  localparam logic [ALUOP_W-1:0] EXE_SRL_OP  = 8'b0000_0010;
  localparam logic [ALUOP_W-1:0] EXE_SRA_OP  = 8'b0000_0011;
  localparam logic [ALUOP_W-1:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [ALUOP_W-1:0] EXE_DIVU_OP = 8'b0001_1011;

  // alusel encodings (result class); divides write HI/LO only, so they use NOP
  localparam logic [ALUSEL_W-1:0] EXE_RES_NOP   = 3'b000;
  localparam logic [ALUSEL_W-1:0] EXE_RES_LOGIC = 3'b001;
  localparam logic [ALUSEL_W-1:0] EXE_RES_SHIFT = 3'b010;

  // Divider sequencing states
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    DIV_ON   = 2'b01,
    DIV_ZERO = 2'b10,
    DIV_END  = 2'b11
  } div_state_e;

  // Decode-stage outputs as captured by the execute input latch
  typedef struct packed {
    logic [ALUOP_W-1:0]    aluop;
    logic [ALUSEL_W-1:0]   alusel;
    logic [DATA_W-1:0]     reg1;
    logic [DATA_W-1:0]     reg2;
    logic [REG_ADDR_W-1:0] wd;
    logic                  wreg;
  } ex_in_t;

  localparam ex_in_t EX_IN_NOP = '0;

  function automatic logic is_div_op(input logic [ALUOP_W-1:0] op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// div_unit: 32/32 restoring divider, one quotient bit per cycle, signed or unsigned.
// Latency: start edge loads operands, then 32 iteration edges; ready is high in the
// cycle whose closing edge commits the last bit, so result is valid from the next cycle.
// Backpressure: none; once started it runs to completion unless rst is asserted.
// Ports: clk, rst (sync, active-high), start (load operands), signed_i (DIV vs DIVU),
//        opdata1 (dividend), opdata2 (divisor) -> result {remainder, quotient}, ready.
module div_unit
  import ex_stage_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                signed_i,
  input  logic [DATA_W-1:0]   opdata1,
  input  logic [DATA_W-1:0]   opdata2,
  output logic [2*DATA_W-1:0] result,
  output logic                ready
);

  logic              busy_q, busy_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] quo_q, quo_d;   // dividend shifts out the top, quotient in the bottom
  logic [DATA_W-1:0] dvs_q, dvs_d;
  logic              negq_q, negq_d;
  logic              negr_q, negr_d;

  logic [DATA_W-1:0] abs1;
  logic [DATA_W-1:0] abs2;
  logic [DATA_W:0]   partial;
  logic [DATA_W:0]   diff;
  logic              fits;

  always_comb begin
    abs1    = (signed_i && opdata1[DATA_W-1]) ? (~opdata1 + 32'd1) : opdata1;
    abs2    = (signed_i && opdata2[DATA_W-1]) ? (~opdata2 + 32'd1) : opdata2;
    partial = {rem_q, quo_q[DATA_W-1]};
    diff    = partial - {1'b0, dvs_q};
    // partial < 2*divisor always holds, so a clear borrow bit means it fits
    fits    = ~diff[DATA_W];

    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    negq_d = negq_q;
    negr_d = negr_q;

    if (start) begin
      cnt_d = '0;
      rem_d = '0;
      if (opdata2 == '0) begin
        // Divide by zero: load an all-zero result and never iterate
        busy_d = 1'b0;
        quo_d  = '0;
        dvs_d  = '0;
        negq_d = 1'b0;
        negr_d = 1'b0;
      end else begin
        busy_d = 1'b1;
        quo_d  = abs1;
        dvs_d  = abs2;
        negq_d = signed_i && (opdata1[DATA_W-1] ^ opdata2[DATA_W-1]);
        negr_d = signed_i && opdata1[DATA_W-1];
      end
    end else if (busy_q) begin
      rem_d = fits ? diff[DATA_W-1:0] : partial[DATA_W-1:0];
      quo_d = {quo_q[DATA_W-2:0], fits};
      cnt_d = cnt_q + 5'd1;
      if (cnt_q == 5'd31) begin
        busy_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      negq_q <= 1'b0;
      negr_q <= 1'b0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
      negq_q <= negq_d;
      negr_q <= negr_d;
    end
  end

  assign ready  = busy_q && (cnt_q == 5'd31);
  // Remainder follows the dividend's sign; quotient negated when signs differ
  assign result = {(negr_q ? (~rem_q + 32'd1) : rem_q),
                   (negq_q ? (~quo_q + 32'd1) : quo_q)};

endmodule

// File: rtl/ex_stage.sv
// ex_stage: execute stage with logic/shift ALU and an iterative HI/LO divider.
// Latency: logic/shift results 1 cycle after capture; DIV/DIVU hold the stage for
// 33 cycles (2 for a zero divisor) then present HI/LO for one cycle.
// Backpressure: stall_i freezes the input latch (and DIV_END); stallreq_o asks the
// controller to freeze upstream while a divide is pending or running.
// Ports: clk, rst (sync, active-high); decode inputs aluop_i/alusel_i/reg1_i/reg2_i/
//        wd_i/wreg_i; stall_i; GPR write wd_o/wreg_o/wdata_o; HI/LO write hi_o/lo_o/
//        whilo_o; stallreq_o.
module ex_stage
  import ex_stage_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  stall_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o,
  output logic                  whilo_o,
  output logic                  stallreq_o
);

  ex_in_t              in_q, in_d;
  div_state_e          state_q, state_d;

  logic                div_start;
  logic                div_ready;
  logic [2*DATA_W-1:0] div_result;
  logic                div_pending;

  logic [DATA_W-1:0]   logic_res;
  logic                logic_vld;
  logic [DATA_W-1:0]   shift_res;
  logic                shift_vld;
  logic [4:0]          shamt;

  // ---------------------------------------------------------------- input latch
  always_comb begin
    in_d = in_q;
    if (!stall_i && !stallreq_o) begin
      in_d.aluop  = aluop_i;
      in_d.alusel = alusel_i;
      in_d.reg1   = reg1_i;
      in_d.reg2   = reg2_i;
      in_d.wd     = wd_i;
      in_d.wreg   = wreg_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      in_q <= EX_IN_NOP;
    end else begin
      in_q <= in_d;
    end
  end

  // ---------------------------------------------------------------- divider FSM
  assign div_pending = is_div_op(in_q.aluop);

  always_comb begin
    state_d    = state_q;
    div_start  = 1'b0;
    stallreq_o = 1'b0;
    case (state_q)
      IDLE: begin
        if (div_pending) begin
          // Operands are sampled into div_unit on the edge that leaves IDLE
          stallreq_o = 1'b1;
          div_start  = 1'b1;
          state_d    = (in_q.reg2 == '0) ? DIV_ZERO : DIV_ON;
        end
      end
      DIV_ON: begin
        stallreq_o = 1'b1;
        if (div_ready) begin
          state_d = DIV_END;
        end
      end
      DIV_ZERO: begin
        stallreq_o = 1'b1;
        state_d    = DIV_END;
      end
      DIV_END: begin
        // Leaving DIV_END coincides with the latch taking the next instruction
        if (!stall_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  div_unit u_div (
    .clk      (clk),
    .rst      (rst),
    .start    (div_start),
    .signed_i (in_q.aluop == EXE_DIV_OP),
    .opdata1  (in_q.reg1),
    .opdata2  (in_q.reg2),
    .result   (div_result),
    .ready    (div_ready)
  );

  // ---------------------------------------------------------------- logic / shift
  assign shamt = in_q.reg1[4:0];

  always_comb begin
    logic_res = '0;
    logic_vld = 1'b1;
    case (in_q.aluop)
      EXE_OR_OP:  logic_res = in_q.reg1 | in_q.reg2;
      EXE_AND_OP: logic_res = in_q.reg1 & in_q.reg2;
      EXE_XOR_OP: logic_res = in_q.reg1 ^ in_q.reg2;
      EXE_NOR_OP: logic_res = ~(in_q.reg1 | in_q.reg2);
      default:    logic_vld = 1'b0;
    endcase
  end

  always_comb begin
    shift_res = '0;
    shift_vld = 1'b1;
    case (in_q.aluop)
      EXE_SLL_OP: shift_res = in_q.reg2 << shamt;
      EXE_SRL_OP: shift_res = in_q.reg2 >> shamt;
      EXE_SRA_OP: shift_res = $unsigned($signed(in_q.reg2) >>> shamt);
      default:    shift_vld = 1'b0;
    endcase
  end

  // ---------------------------------------------------------------- outputs
  always_comb begin
    wd_o    = in_q.wd;
    wreg_o  = 1'b0;
    wdata_o = '0;
    hi_o    = '0;
    lo_o    = '0;
    whilo_o = 1'b0;

    // An op only writes the GPR when its aluop matches the result class selected;
    // NOP, divides and unknown encodings leave wreg_o low.
    case (in_q.alusel)
      EXE_RES_LOGIC: begin
        if (logic_vld) begin
          wdata_o = logic_res;
          wreg_o  = in_q.wreg;
        end
      end
      EXE_RES_SHIFT: begin
        if (shift_vld) begin
          wdata_o = shift_res;
          wreg_o  = in_q.wreg;
        end
      end
      default: ;
    endcase

    if (state_q == DIV_END) begin
      hi_o    = div_result[2*DATA_W-1:DATA_W];
      lo_o    = div_result[DATA_W-1:0];
      whilo_o = 1'b1;
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: logic/shift ops, stall hold, DIV/DIVU timing and
// results, divide-by-zero, stall in DIV_END and reset abort of a running divide.
module tb_ex_stage;
  import ex_stage_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i;
  logic [31:0] reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i;
  logic        stall_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;
  logic        whilo_o;
  logic        stallreq_o;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  ex_stage dut (
    .clk        (clk),
    .rst        (rst),
    .aluop_i    (aluop_i),
    .alusel_i   (alusel_i),
    .reg1_i     (reg1_i),
    .reg2_i     (reg2_i),
    .wd_i       (wd_i),
    .wreg_i     (wreg_i),
    .stall_i    (stall_i),
    .wd_o       (wd_o),
    .wreg_o     (wreg_o),
    .wdata_o    (wdata_o),
    .hi_o       (hi_o),
    .lo_o       (lo_o),
    .whilo_o    (whilo_o),
    .stallreq_o (stallreq_o)
  );

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [4:0] wd, input logic wr);
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
    wd_i     = wd;
    wreg_i   = wr;
  endtask

  // Inputs must already hold the divide. Returns at the first cycle with stallreq_o
  // low (DIV_END) or after the cycle budget. stall_i is raised for stall cycles
  // st_from..st_to; the inputs are replaced by OR 1|2 (wd 8) after capture.
  task automatic run_div(input int st_from, input int st_to, output int stalls);
    stalls = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (i == 0) set_in(EXE_OR_OP, EXE_RES_LOGIC, 32'd1, 32'd2, 5'd8, 1'b1);
      if (stallreq_o) begin
        stalls++;
        stall_i = (stalls >= st_from) && (stalls <= st_to);
      end else begin
        break;
      end
    end
    stall_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int stalls;
    int whilo_seen;
    int stall_seen;

    rst     = 1'b1;
    stall_i = 1'b0;
    set_in(8'h25, EXE_RES_LOGIC, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd31, 1'b1);
    tick();
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_wreg", 32'(wreg_o), 32'd0);
    check("rst_wd", 32'(wd_o), 32'd0);
    check("rst_whilo", 32'(whilo_o), 32'd0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    check("rst_stallreq", 32'(stallreq_o), 32'd0);
    rst = 1'b0;

    // Logic ops
    set_in(EXE_OR_OP, EXE_RES_LOGIC, 32'h0000_FF00, 32'h0F0F_0000, 5'd5, 1'b1);
    tick();
    check("or_wdata", wdata_o, 32'h0F0F_FF00);
    check("or_wreg", 32'(wreg_o), 32'd1);
    check("or_wd", 32'(wd_o), 32'd5);
    check("or_whilo", 32'(whilo_o), 32'd0);

    set_in(EXE_AND_OP, EXE_RES_LOGIC, 32'hF0F0_1234, 32'h0FF0_FF00, 5'd3, 1'b1);
    tick();
    check("and_wdata", wdata_o, 32'h00F0_1200);
    check("and_wd", 32'(wd_o), 32'd3);

    set_in(EXE_XOR_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd4, 1'b1);
    tick();
    check("xor_wdata", wdata_o, 32'hF0F0_0F0F);

    set_in(EXE_NOR_OP, EXE_RES_LOGIC, 32'h0000_00F0, 32'h0F00_0000, 5'd6, 1'b0);
    tick();
    check("nor_wdata", wdata_o, 32'hF0FF_FF0F);
    check("nor_wreg", 32'(wreg_o), 32'd0);

    // Shifts
    set_in(EXE_SRA_OP, EXE_RES_SHIFT, 32'd4, 32'h8000_0000, 5'd7, 1'b1);
    tick();
    check("sra4_wdata", wdata_o, 32'hF800_0000);

    set_in(EXE_SLL_OP, EXE_RES_SHIFT, 32'd8, 32'h0000_00AB, 5'd7, 1'b1);
    tick();
    check("sll_wdata", wdata_o, 32'h0000_AB00);

    set_in(EXE_SRA_OP, EXE_RES_SHIFT, 32'h24, 32'h8000_0000, 5'd7, 1'b1);
    tick();
    check("sra24_wdata", wdata_o, 32'hF800_0000);

    set_in(EXE_SRL_OP, EXE_RES_SHIFT, 32'h21, 32'h8000_0000, 5'd2, 1'b1);
    tick();
    check("srl_wdata", wdata_o, 32'h4000_0000);
    check("srl_wreg", 32'(wreg_o), 32'd1);

    // Unknown op and NOP
    set_in(8'hFF, EXE_RES_LOGIC, 32'h1234_5678, 32'h9ABC_DEF0, 5'd9, 1'b1);
    tick();
    check("unk_wdata", wdata_o, 32'h0);
    check("unk_wreg", 32'(wreg_o), 32'd0);
    check("unk_wd", 32'(wd_o), 32'd9);

    set_in(EXE_NOP_OP, EXE_RES_NOP, 32'h1, 32'h1, 5'd11, 1'b1);
    tick();
    check("nop_wreg", 32'(wreg_o), 32'd0);
    check("nop_wdata", wdata_o, 32'h0);

    // Stall hold with an AND latched
    set_in(EXE_AND_OP, EXE_RES_LOGIC, 32'hFFFF_0000, 32'h1234_5678, 5'd7, 1'b1);
    tick();
    check("stl_pre_wdata", wdata_o, 32'h1234_0000);
    stall_i = 1'b1;
    set_in(EXE_OR_OP, EXE_RES_LOGIC, 32'd1, 32'd2, 5'd8, 1'b1);
    tick();
    check("stl_hold1_wdata", wdata_o, 32'h1234_0000);
    check("stl_hold1_wd", 32'(wd_o), 32'd7);
    tick();
    check("stl_hold2_wdata", wdata_o, 32'h1234_0000);
    stall_i = 1'b0;
    tick();
    check("stl_rel_wdata", wdata_o, 32'h0000_0003);
    check("stl_rel_wd", 32'(wd_o), 32'd8);

    // DIVU 100 / 7
    set_in(EXE_DIVU_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd10, 1'b1);
    run_div(0, -1, stalls);
    check("divu_stalls", 32'(stalls), 32'd33);
    check("divu_whilo", 32'(whilo_o), 32'd1);
    check("divu_lo", lo_o, 32'd14);
    check("divu_hi", hi_o, 32'd2);
    check("divu_wreg", 32'(wreg_o), 32'd0);
    check("divu_wd", 32'(wd_o), 32'd10);
    tick();
    check("divu_after_whilo", 32'(whilo_o), 32'd0);
    check("divu_after_wdata", wdata_o, 32'h0000_0003);
    check("divu_after_stallreq", 32'(stallreq_o), 32'd0);

    // DIV -7 / 2 with stall_i pulsed during DIV_ON
    set_in(EXE_DIV_OP, EXE_RES_NOP, 32'hFFFF_FFF9, 32'd2, 5'd12, 1'b1);
    run_div(5, 10, stalls);
    check("divs_stalls", 32'(stalls), 32'd33);
    check("divs_lo", lo_o, 32'hFFFF_FFFD);
    check("divs_hi", hi_o, 32'hFFFF_FFFF);
    check("divs_whilo", 32'(whilo_o), 32'd1);
    tick();

    // DIV 0x80000000 / -1, stall_i held in DIV_END
    set_in(EXE_DIV_OP, EXE_RES_NOP, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 1'b0);
    run_div(0, -1, stalls);
    check("ovf_stalls", 32'(stalls), 32'd33);
    check("ovf_lo", lo_o, 32'h8000_0000);
    check("ovf_hi", hi_o, 32'h0);
    stall_i = 1'b1;
    tick();
    check("end_hold_whilo", 32'(whilo_o), 32'd1);
    check("end_hold_lo", lo_o, 32'h8000_0000);
    check("end_hold_stallreq", 32'(stallreq_o), 32'd0);
    stall_i = 1'b0;
    tick();
    check("end_rel_whilo", 32'(whilo_o), 32'd0);
    check("end_rel_wdata", wdata_o, 32'h0000_0003);

    // DIV 5 / 0
    set_in(EXE_DIV_OP, EXE_RES_NOP, 32'd5, 32'd0, 5'd14, 1'b1);
    run_div(0, -1, stalls);
    check("dz_stalls", 32'(stalls), 32'd2);
    check("dz_whilo", 32'(whilo_o), 32'd1);
    check("dz_lo", lo_o, 32'h0);
    check("dz_hi", hi_o, 32'h0);
    tick();

    // Reset at iteration 10 of a divide
    set_in(EXE_DIVU_OP, EXE_RES_NOP, 32'hFFFF_FFFF, 32'd3, 5'd15, 1'b1);
    for (int i = 0; i < 12; i++) tick();
    check("abort_pre_stallreq", 32'(stallreq_o), 32'd1);
    rst = 1'b1;
    set_in(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0, 5'd0, 1'b0);
    tick();
    rst = 1'b0;
    check("abort_stallreq", 32'(stallreq_o), 32'd0);
    check("abort_wd", 32'(wd_o), 32'd0);
    check("abort_wreg", 32'(wreg_o), 32'd0);
    check("abort_wdata", wdata_o, 32'h0);
    check("abort_lo", lo_o, 32'h0);
    whilo_seen = 0;
    stall_seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (whilo_o) whilo_seen++;
      if (stallreq_o) stall_seen++;
    end
    check("abort_no_whilo", 32'(whilo_seen), 32'd0);
    check("abort_no_stall", 32'(stall_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
